mem_wb_stage: RTL
=================

# mem_wb_stage

MEM/WB pipeline register and write-back logic for the pipelined MIPS datapath. It captures the MEM-stage result, extracts and extends load data, and selects the final result. It drives the register file write port (`write_enable`, `write_Reg`, `write_data`) directly from flops. It also keeps a retired-instruction counter and a sticky halt flag for the debug unit.

## Interface
- `WIDTH`, 32: datapath width.
- `WIDTH_ADD`, 5: register address width.

- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `stall`  in  1  hold the stage register.
- `flush`  in  1  load a bubble.
- `mem_valid`  in  1  MEM holds a real instruction.
- `mem_reg_write`  in  1  instruction writes a register.
- `mem_to_reg`  in  1  result is load data.
- `mem_link`  in  1  result is return address (jal/jalr).
- `mem_load_size`  in  2  00 byte, 01 half, 10/11 word.
- `mem_load_unsigned`  in  1  zero-extend (lbu/lhu).
- `mem_byte_off`  in  2  address[1:0] of the load.
- `mem_halt`  in  1  halt instruction.
- `mem_write_reg`  in  WIDTH_ADD  destination register.
- `mem_alu_result`  in  WIDTH  ALU result.
- `mem_read_data`  in  WIDTH  raw data-memory word.
- `mem_return_addr`  in  WIDTH  PC+8.
- `write_enable`  out  1  register file write strobe.
- `write_Reg`  out  WIDTH_ADD  register file write address.
- `write_data`  out  WIDTH  register file write data.
- `wb_valid`  out  1  stage holds a real instruction.
- `halted`  out  1  sticky halt flag.
- `instr_count`  out  32  retired-instruction counter.

## Operation
- Result mux priority: `mem_link` > `mem_to_reg` > `mem_alu_result`.
- Load extraction is little-endian:
  - Byte: lane = `mem_byte_off`, bits [8·off+7 : 8·off].
  - Half: `mem_byte_off[1]` selects [15:0] (0) or [31:16] (1). `mem_byte_off[0]` is ignored and no misalignment trap is raised.
  - Word: offset ignored.
  - Sign-extend unless `mem_load_unsigned`.
- Capture computes `write_enable` = `mem_valid & mem_reg_write & (mem_write_reg != 0)` and registers it. A write to register 0 is suppressed, but the instruction still retires.
- Register update priority per posedge:
  1. `halted`: hold a bubble; no retire.
  2. `flush`: bubble. `wb_valid` = 0 and `write_enable` = 0. `write_Reg`/`write_data` are don't-care and kept at 0.
  3. `stall`: hold all outputs.
  4. Otherwise: capture.
- Retire: on a capture with `mem_valid` = 1, `instr_count` += 1. The counter wraps at 2^32 to 0.
- Halt: on a capture with `mem_valid & mem_halt`, set `halted` in the same edge. The halt instruction counts as retired and never writes a register. `halted` clears only on reset.
- While stalled with a valid write held, `write_enable` stays high. The register file rewrites the same value each negedge, which is idempotent and required.

## Timing
- Reset (async, `reset` = 0): all outputs 0 (`write_enable`, `write_Reg`, `write_data`, `wb_valid`, `halted`, `instr_count`). Reset mid-stall or mid-halt discards the held instruction.
- Latency is 1 cycle: MEM inputs at posedge N appear on the outputs after posedge N.
- The register file writes on the following negedge, so ID reads in the second half of that cycle see the new value. This stage adds no internal forwarding.
- All outputs come straight from flops, with no combinational path from inputs to outputs.
- `stall` and `flush` together: flush wins.
- `flush` while `halted`: the stage stays a bubble and `halted` stays 1.

## Structure
- Shared package holds:
  - Load size encodings: `LS_BYTE` = 2'b00, `LS_HALF` = 2'b01, `LS_WORD` = 2'b10.
  - Datapath width constants shared with the register file and the EX/MEM register.
- One combinational sub-module, `load_extract`:
  - Inputs: raw word, size, offset, unsigned.
  - Output: extended WIDTH value.
- The stage register, result mux, counter and halt flag live in `mem_wb_stage`.

## Test plan
- Reset mid-operation:
  - Capture a valid write (`mem_write_reg` = 5, `mem_alu_result` = 0x1234, `instr_count` = 3), then assert `reset` = 0 between clock edges.
  - Required: all outputs 0 immediately; `instr_count` = 0.
- Byte loads with `mem_read_data` = 0x80FF_1234, offset 3:
  - lb → `write_data` = 0xFFFF_FF80.
  - lbu → `write_data` = 0x0000_0080.
  - lb offset 1 → `write_data` = 0x0000_0012.
- Half loads with `mem_read_data` = 0x8001_7FFF:
  - lh offset 2 → `write_data` = 0xFFFF_8001.
  - lhu offset 0 → `write_data` = 0x0000_7FFF.
  - lh offset 3 → `write_data` = 0xFFFF_8001 (bit 0 of the offset is ignored).
- Register 0 and link:
  - Write to register 0 → `write_enable` = 0, `wb_valid` = 1, count +1.
  - jal with `mem_link` = 1, `mem_return_addr` = 0x108, `mem_to_reg` = 1, `mem_write_reg` = 31 → `write_Reg` = 31, `write_data` = 0x108.
- Stall and flush:
  - Stall 3 cycles holding a write to register 7 → outputs unchanged and `instr_count` unchanged for 3 cycles.
  - Stall and flush asserted together → `wb_valid` = 0, `write_enable` = 0.
- Halt and counter wrap:
  - Halt instruction → `halted` = 1, count +1; later valid inputs are ignored and the count is frozen.
  - Preload 0xFFFF_FFFF retirements, then one more → `instr_count` = 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared datapath widths and load-size encodings
package mem_wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// load_extract: little-endian byte/half/word lane select with sign or zero extension
module load_extract
  import mem_wb_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] raw_i,
  input  logic [1:0]       size_i,
  input  logic [1:0]       off_i,
  input  logic             uns_i,
  output logic [WIDTH-1:0] data_o
);
  logic [WIDTH-1:0] byte_sh, half_sh;
  logic [7:0]       b;
  logic [15:0]      h;
  always_comb begin
    byte_sh = raw_i >> {off_i, 3'b000};
    half_sh = raw_i >> {off_i[1], 4'b0000};
    b       = byte_sh[7:0];
    h       = half_sh[15:0];
    data_o  = size_i == LS_BYTE ? {{(WIDTH-8){~uns_i & b[7]}}, b} :
              size_i == LS_HALF ? {{(WIDTH-16){~uns_i & h[15]}}, h} : raw_i;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register driving the register-file write port, plus retire counter and sticky halt
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int WIDTH_ADD = ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic                 mem_to_reg,
  input  logic                 mem_link,
  input  logic [1:0]           mem_load_size,
  input  logic                 mem_load_unsigned,
  input  logic [1:0]           mem_byte_off,
  input  logic                 mem_halt,
  input  logic [WIDTH_ADD-1:0] mem_write_reg,
  input  logic [WIDTH-1:0]     mem_alu_result,
  input  logic [WIDTH-1:0]     mem_read_data,
  input  logic [WIDTH-1:0]     mem_return_addr,
  output logic                 write_enable,
  output logic [WIDTH_ADD-1:0] write_Reg,
  output logic [WIDTH-1:0]     write_data,
  output logic                 wb_valid,
  output logic                 halted,
  output logic [31:0]          instr_count
);
  logic [WIDTH-1:0]     load_data, data_d, data_q;
  logic                 we_d, we_q, valid_q, halted_q;
  logic [WIDTH_ADD-1:0] reg_q;
  logic [31:0]          instr_cnt_q;

  load_extract #(.WIDTH(WIDTH)) u_load_extract (
    .raw_i  (mem_read_data),
    .size_i (mem_load_size),
    .off_i  (mem_byte_off),
    .uns_i  (mem_load_unsigned),
    .data_o (load_data)
  );

  // halt never writes; register 0 writes are dropped but still retire
  always_comb begin
    data_d = mem_link ? mem_return_addr : mem_to_reg ? load_data : mem_alu_result;
    we_d   = mem_valid & mem_reg_write & ~mem_halt & (mem_write_reg != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      reg_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else if (halted_q || flush) begin
      we_q    <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      we_q        <= we_d;
      reg_q       <= mem_write_reg;
      data_q      <= data_d;
      valid_q     <= mem_valid;
      halted_q    <= mem_valid & mem_halt;
      instr_cnt_q <= instr_cnt_q + {31'b0, mem_valid};
    end
  end

  assign write_enable = we_q;
  assign write_Reg    = reg_q;
  assign write_data   = data_q;
  assign wb_valid     = valid_q;
  assign halted       = halted_q;
  assign instr_count  = instr_cnt_q;
endmodule
